// File: rtl/iobuf_dci_pkg.sv
// Shared types and constants for the DCI-calibrated IO bank.
package iobuf_dci_pkg;

    typedef enum logic {
        CAL   = 1'b0,
        READY = 1'b1
    } cal_state_e;

    localparam int unsigned DEFAULT_CAL_CYCLES = 16;

    // Calibration counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/dci_cal_fsm.sv
// DCI calibration sequencer: runs a fixed-length pass after reset and on request,
// and decides when the pad drivers must be held off.
module dci_cal_fsm
    import iobuf_dci_pkg::*;
#(
    parameter int unsigned CAL_CYCLES = DEFAULT_CAL_CYCLES,
    parameter bit          RECAL_HOLD = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cal_req,
    output logic dci_locked,
    output logic cal_busy,
    output logic drive_off_c
);

    localparam int unsigned    CW       = cnt_width(CAL_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CAL_CYCLES - 1);

    cal_state_e    state;
    logic [CW-1:0] cnt;
    logic          first_cal;

    // Requests arriving while a pass is running, or on its final edge, are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CAL;
            cnt        <= '0;
            first_cal  <= 1'b1;
            dci_locked <= 1'b0;
            cal_busy   <= 1'b0;
        end else begin
            case (state)
                CAL: begin
                    if (cnt == CNT_LAST) begin
                        state      <= READY;
                        cnt        <= '0;
                        first_cal  <= 1'b0;
                        dci_locked <= 1'b1;
                        cal_busy   <= 1'b0;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        cal_busy <= 1'b1;
                    end
                end
                READY: begin
                    if (cal_req) begin
                        state      <= CAL;
                        dci_locked <= 1'b0;
                        cal_busy   <= 1'b1;
                    end
                end
                default: state <= CAL;
            endcase
        end
    end

    // Only the very first pass gates the drivers unless recalibration hold is enabled.
    assign drive_off_c = !dci_locked && (first_cal || RECAL_HOLD);

endmodule

// File: rtl/iobuf_bank_dci.sv
// Registered bidirectional SSTL18 IO bank with per-bit tri-state and DCI-gated drive.
module iobuf_bank_dci
    import iobuf_dci_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CAL_CYCLES = DEFAULT_CAL_CYCLES,
    parameter logic        T_INIT     = 1'b1,
    parameter bit          RECAL_HOLD = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] O,
    inout  wire  [WIDTH-1:0] IO,
    input  logic             CAL_REQ,
    output logic             DCI_LOCKED,
    output logic             CAL_BUSY
);

    logic drive_off_c;

    dci_cal_fsm #(
        .CAL_CYCLES (CAL_CYCLES),
        .RECAL_HOLD (RECAL_HOLD)
    ) u_cal (
        .clk         (CLK),
        .rst_n       (RST_N),
        .cal_req     (CAL_REQ),
        .dci_locked  (DCI_LOCKED),
        .cal_busy    (CAL_BUSY),
        .drive_off_c (drive_off_c)
    );

    // One IOB-style slice per bit; the input flop samples the pad even while driving.
    for (genvar k = 0; k < WIDTH; k++) begin : g_pad
        logic i_q;
        logic t_q;
        logic o_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                i_q <= 1'b0;
                t_q <= T_INIT;
                o_q <= 1'b0;
            end else begin
                i_q <= I[k];
                t_q <= T[k];
                o_q <= IO[k];
            end
        end

        assign IO[k] = (t_q || drive_off_c) ? 1'bz : i_q;
        assign O[k]  = o_q;
    end

endmodule

// File: tb/tb_iobuf_bank_dci.sv
// Directed bench for iobuf_bank_dci: one bank with RECAL_HOLD=0, one with RECAL_HOLD=1.
module tb_iobuf_bank_dci;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       cal_req = 1'b0;
    logic [7:0] din     = 8'hA5;
    logic [7:0] tin     = 8'h00;
    logic [7:0] ext_en  = 8'h00;
    logic [7:0] ext_val = 8'h00;

    wire  [7:0] pad;
    wire  [7:0] pad_h;
    logic [7:0] dout, dout_h;
    logic       locked, busy, locked_h, busy_h;
    logic [39:0] lock_hist;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Pull-ups make an undriven pad read as 1, so high-Z is observable.
    for (genvar k = 0; k < 8; k++) begin : g_term
        pullup pu_a (pad[k]);
        pullup pu_h (pad_h[k]);
        assign pad[k] = ext_en[k] ? ext_val[k] : 1'bz;
    end

    iobuf_bank_dci #(.WIDTH(8), .CAL_CYCLES(16), .T_INIT(1'b1), .RECAL_HOLD(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .I(din), .T(tin), .O(dout), .IO(pad),
        .CAL_REQ(cal_req), .DCI_LOCKED(locked), .CAL_BUSY(busy)
    );

    iobuf_bank_dci #(.WIDTH(8), .CAL_CYCLES(16), .T_INIT(1'b1), .RECAL_HOLD(1'b1)) dut_h (
        .CLK(clk), .RST_N(rst_n), .I(din), .T(tin), .O(dout_h), .IO(pad_h),
        .CAL_REQ(cal_req), .DCI_LOCKED(locked_h), .CAL_BUSY(busy_h)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: everything quiet, pads high-Z.
        #12;
        chk("rst_o",      64'(dout),   64'h00);
        chk("rst_lock",   64'(locked), 64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_pad",    64'(pad),    64'hFF);
        chk("rst_pad_h",  64'(pad_h),  64'hFF);
        repeat (2) tick();

        // First calibration pass: 16 edges with the drivers gated.
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n < 16) begin
                chk("cal1_lock",  64'(locked), 64'h0);
                chk("cal1_busy",  64'(busy),   64'h1);
                chk("cal1_pad",   64'(pad),    64'hFF);
                chk("cal1_pad_h", 64'(pad_h),  64'hFF);
            end
        end
        chk("lock1",       64'(locked),   64'h1);
        chk("lock1_busy",  64'(busy),     64'h0);
        chk("lock1_h",     64'(locked_h), 64'h1);
        chk("drive1_pad",  64'(pad),      64'hA5);
        chk("drive1_padh", 64'(pad_h),    64'hA5);
        chk("drive1_o",    64'(dout),     64'hFF);
        tick();
        chk("loop1_o",     64'(dout),     64'hA5);

        // Per-bit tri-state, then an external driver on the released nibble.
        din = 8'h00; tin = 8'hF0;
        tick();
        chk("tri_pad", 64'(pad), 64'hF0);
        tick();
        chk("tri_o",   64'(dout), 64'hF0);
        din = 8'hFF; ext_val = 8'h30; ext_en = 8'hF0;
        tick();
        chk("ext_pad", 64'(pad), 64'h3F);
        tick();
        chk("ext_o",   64'(dout), 64'h3F);
        ext_en = 8'h00; tin = 8'h00; din = 8'h5A;
        tick();
        chk("redrive_pad", 64'(pad), 64'h5A);

        // Recalibration: hold=0 keeps driving, hold=1 floats.
        cal_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            cal_req = 1'b0;
            chk("recal_busy",  64'(busy),    64'h1);
            chk("recal_lock",  64'(locked),  64'h0);
            chk("recal_bush",  64'(busy_h),  64'h1);
            chk("recal_pad",   64'(pad),     64'h5A);
            chk("recal_pad_h", 64'(pad_h),   64'hFF);
        end
        tick();
        chk("recal_done",   64'(locked), 64'h1);
        chk("recal_idle",   64'(busy),   64'h0);
        chk("recal_pad_h2", 64'(pad_h),  64'h5A);

        // Extra requests mid-pass and on the completing edge are ignored.
        cal_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            cal_req = (k == 2 || k == 8 || k == 15);
            chk("multi_lock", 64'(locked), 64'h0);
        end
        tick();
        cal_req = 1'b0;
        chk("multi_done", 64'(locked), 64'h1);
        tick();
        chk("req_on_done", 64'(locked), 64'h1);
        chk("req_on_busy", 64'(busy),   64'h0);

        // Asynchronous reset between edges while driving.
        din = 8'hC3;
        tick();
        chk("pre_rst_o", 64'(dout), 64'h5A);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pad",   64'(pad),    64'hFF);
        chk("arst_pad_h", 64'(pad_h),  64'hFF);
        chk("arst_o",     64'(dout),   64'h00);
        chk("arst_o_h",   64'(dout_h), 64'h00);
        chk("arst_lock",  64'(locked), 64'h0);
        chk("arst_busy",  64'(busy),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n < 16) begin
                chk("cal2_lock", 64'(locked), 64'h0);
                chk("cal2_pad",  64'(pad),    64'hFF);
            end
        end
        chk("lock2",     64'(locked), 64'h1);
        chk("lock2_pad", 64'(pad),    64'hC3);

        // Request held high: one-cycle lock pulses between back-to-back passes.
        cal_req = 1'b1;
        lock_hist = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            lock_hist[k] = locked;
        end
        cal_req = 1'b0;
        chk("held_lock_hist", 64'(lock_hist), 64'h02_0001_0000);
        for (int k = 0; k < 30; k++) begin
            if (!locked) tick();
        end
        chk("held_relock", 64'(locked), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
